// File: rtl/spi_word_receiver.sv
// SPI slave receiver: oversampled SCK/CS/SDI, any word width, any SPI mode,
// either bit order, show-ahead receive FIFO with sticky error flags.
module spi_word_receiver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       sck,
    input  logic                       cs,
    input  logic                       sdi,
    input  logic                       pop,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       we,
    output logic                       overflow,
    output logic                       frame_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned BW = $clog2(WIDTH);

    // Reception is only armed once a genuine idle (cs high) has been seen
    // after reset; the two flush states let real input reach the synchroniser.
    typedef enum logic [1:0] {
        ST_FLUSH0,
        ST_FLUSH1,
        ST_WAIT_IDLE,
        ST_READY
    } state_t;

    state_t state_q, state_d;

    logic sck_q1, sck_q2, sck_q3;
    logic cs_q1, cs_q2, cs_q3;
    logic sdi_q1, sdi_q2;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             push_q, push_d;
    logic             fe_pend_q, fe_pend_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             we_q, ovf_q, ovf_d, ferr_q, ferr_d;

    logic sample_edge, cs_rise, bit_en;
    logic do_pop, do_push, full, ovf_set;

    assign sample_edge = (CPOL ^ CPHA) ? (~sck_q2 & sck_q3) : (sck_q2 & ~sck_q3);
    assign cs_rise     = cs_q2 & ~cs_q3;
    assign bit_en      = (state_q == ST_READY) && !cs_q2 && sample_edge;

    // Two-flop synchronisers plus a third flop on sck/cs for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sck_q1 <= CPOL;
            sck_q2 <= CPOL;
            sck_q3 <= CPOL;
            cs_q1  <= 1'b1;
            cs_q2  <= 1'b1;
            cs_q3  <= 1'b1;
            sdi_q1 <= 1'b0;
            sdi_q2 <= 1'b0;
        end else begin
            sck_q1 <= sck;
            sck_q2 <= sck_q1;
            sck_q3 <= sck_q2;
            cs_q1  <= cs;
            cs_q2  <= cs_q1;
            cs_q3  <= cs_q2;
            sdi_q1 <= sdi;
            sdi_q2 <= sdi_q1;
        end
    end

    // Arming state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_FLUSH0;
        else       state_q <= state_d;
    end

    // Arming next-state: wait for synchronised cs high before accepting bits.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FLUSH0:    state_d = ST_FLUSH1;
            ST_FLUSH1:    state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (cs_q2) state_d = ST_READY;
            ST_READY:     state_d = ST_READY;
            default:      state_d = ST_FLUSH0;
        endcase
    end

    // Shift register, bit counter, word-complete and frame-error detection.
    always_comb begin
        shift_d   = shift_q;
        bcnt_d    = bcnt_q;
        push_d    = 1'b0;
        fe_pend_d = 1'b0;
        if (cs_rise && bcnt_q != '0) begin
            bcnt_d    = '0;
            fe_pend_d = 1'b1;
        end else if (bit_en) begin
            shift_d = LSB_FIRST ? {sdi_q2, shift_q[WIDTH-1:1]}
                                : {shift_q[WIDTH-2:0], sdi_q2};
            if (bcnt_q == BW'(WIDTH-1)) begin
                bcnt_d = '0;
                push_d = 1'b1;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // Receive path registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shift_q   <= '0;
            bcnt_q    <= '0;
            push_q    <= 1'b0;
            fe_pend_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bcnt_q    <= bcnt_d;
            push_q    <= push_d;
            fe_pend_q <= fe_pend_d;
        end
    end

    // FIFO control: a pop frees the slot a simultaneous full-FIFO push needs.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        full    = (count_q == CW'(DEPTH));
        do_push = push_q && (!full || do_pop);
        ovf_set = push_q && full && !do_pop;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
        ovf_d  = (clr_err ? 1'b0 : ovf_q)  | ovf_set;
        ferr_d = (clr_err ? 1'b0 : ferr_q) | fe_pend_q;
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            we_q    <= do_push;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    // FIFO storage; contents are hidden behind rvalid so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= shift_q;
    end

    assign rvalid    = (count_q != '0);
    assign rdata     = rvalid ? mem_q[rptr_q] : '0;
    assign count     = count_q;
    assign we        = we_q;
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_word_receiver.sv
// Scoreboard bench for spi_word_receiver: one default instance and one
// 16-bit, mode-3, MSB-first instance.
module tb_spi_word_receiver;

    logic clk = 1'b0;
    logic nrst;
    logic sck0, cs0, sdi0, pop0, clr0;
    logic sck1, cs1, sdi1, pop1, clr1;
    logic [7:0]  rdata0;
    logic [15:0] rdata1;
    logic [2:0]  count0, count1;
    logic rvalid0, we0, ovf0, ferr0;
    logic rvalid1, we1, ovf1, ferr1;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt0  = 0;
    int we_cnt1  = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    always #5 clk = ~clk;

    spi_word_receiver u_dut0 (
        .clk(clk), .nrst(nrst), .sck(sck0), .cs(cs0), .sdi(sdi0),
        .pop(pop0), .clr_err(clr0), .rdata(rdata0), .rvalid(rvalid0),
        .count(count0), .we(we0), .overflow(ovf0), .frame_err(ferr0)
    );

    spi_word_receiver #(
        .WIDTH(16), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)
    ) u_dut1 (
        .clk(clk), .nrst(nrst), .sck(sck1), .cs(cs1), .sdi(sdi1),
        .pop(pop1), .clr_err(clr1), .rdata(rdata1), .rvalid(rvalid1),
        .count(count1), .we(we1), .overflow(ovf1), .frame_err(ferr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare the head word whenever a pop is presented while valid.
    always @(negedge clk) begin
        if (nrst) begin
            if (pop0 && rvalid0) begin
                if (exp_q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pop0_unexpected: got 0x%0h required none", rdata0);
                end else check("pop0_data", 32'(rdata0), 32'(exp_q0.pop_front()));
            end
            if (pop1 && rvalid1) begin
                if (exp_q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pop1_unexpected: got 0x%0h required none", rdata1);
                end else check("pop1_data", 32'(rdata1), 32'(exp_q1.pop_front()));
            end
            if (we0) we_cnt0++;
            if (we1) we_cnt1++;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sck(input int which, input logic v);
        if (which == 0) sck0 = v; else sck1 = v;
    endtask

    task automatic set_sdi(input int which, input logic v);
        if (which == 0) sdi0 = v; else sdi1 = v;
    endtask

    task automatic set_pop(input int which, input logic v);
        if (which == 0) pop0 = v; else pop1 = v;
    endtask

    // Send nbits of w (half period 5 clk); optionally pop in the push cycle.
    task automatic send(input int which, input logic [15:0] w, input int nbits,
                        input int width, input bit lsb, input bit cpol,
                        input bit cpha, input bit pop_last);
        int idx;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : width - 1 - i;
            if (!cpha) begin
                set_sdi(which, w[idx]);
                clks(5);
                set_sck(which, ~cpol);
            end else begin
                set_sck(which, ~cpol);
                set_sdi(which, w[idx]);
                clks(5);
                set_sck(which, cpol);
            end
            if (pop_last && i == nbits - 1) begin
                clks(3);
                set_pop(which, 1'b1);
                clks(1);
                set_pop(which, 1'b0);
                clks(1);
            end else begin
                clks(5);
            end
            if (!cpha) set_sck(which, cpol);
        end
    endtask

    task automatic pop_word(input int which);
        set_pop(which, 1'b1);
        clks(1);
        set_pop(which, 1'b0);
    endtask

    task automatic send8(input logic [7:0] w);
        send(0, {8'h00, w}, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_rdata"},  32'(rdata0),  32'h0);
        check({tag, "_rvalid"}, 32'(rvalid0), 32'h0);
        check({tag, "_count"},  32'(count0),  32'h0);
        check({tag, "_we"},     32'(we0),     32'h0);
        check({tag, "_ovf"},    32'(ovf0),    32'h0);
        check({tag, "_ferr"},   32'(ferr0),   32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        nrst = 1'b0;
        sck0 = 1'b0; cs0 = 1'b1; sdi0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0;
        sck1 = 1'b1; cs1 = 1'b1; sdi1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0;
        clks(3);
        check_zero0("reset");
        check("reset_rvalid1", 32'(rvalid1), 32'h0);
        nrst = 1'b1;
        clks(6);

        // Single byte, mode 0, LSB first.
        base = we_cnt0;
        cs0 = 1'b0; clks(5);
        send8(8'h9C); exp_q0.push_back(16'h009C);
        clks(5); cs0 = 1'b1; clks(5);
        check("t1_we", 32'(we_cnt0 - base), 32'd1);
        check("t1_count", 32'(count0), 32'd1);
        check("t1_rdata", 32'(rdata0), 32'h9C);
        pop_word(0); clks(1);
        check("t1_rvalid_after_pop", 32'(rvalid0), 32'h0);

        // 16-bit, mode 3, MSB first, two words in one frame.
        base = we_cnt1;
        cs1 = 1'b0; clks(5);
        send(1, 16'hA55A, 16, 16, 1'b0, 1'b1, 1'b1, 1'b0); exp_q1.push_back(16'hA55A);
        send(1, 16'h0FF0, 16, 16, 1'b0, 1'b1, 1'b1, 1'b0); exp_q1.push_back(16'h0FF0);
        clks(5); cs1 = 1'b1; clks(5);
        check("t2_we", 32'(we_cnt1 - base), 32'd2);
        check("t2_count", 32'(count1), 32'd2);
        pop_word(1); pop_word(1); clks(1);
        check("t2_rvalid", 32'(rvalid1), 32'h0);

        // Overflow: five words into a four-deep FIFO.
        base = we_cnt0;
        cs0 = 1'b0; clks(5);
        for (int i = 1; i <= 5; i++) begin
            send8(8'(i));
            if (i <= 4) exp_q0.push_back(16'(i));
        end
        clks(5); cs0 = 1'b1; clks(5);
        check("t3_count", 32'(count0), 32'd4);
        check("t3_ovf", 32'(ovf0), 32'h1);
        check("t3_we", 32'(we_cnt0 - base), 32'd4);
        check("t3_ferr", 32'(ferr0), 32'h0);
        for (int i = 0; i < 4; i++) pop_word(0);
        clks(1);
        check("t3_rvalid", 32'(rvalid0), 32'h0);
        clr0 = 1'b1; clks(1); clr0 = 1'b0; clks(1);
        check("t3_ovf_cleared", 32'(ovf0), 32'h0);

        // Push and pop in the same cycle while full.
        base = we_cnt0;
        cs0 = 1'b0; clks(5);
        for (int i = 1; i <= 5; i++) begin
            exp_q0.push_back(16'(i));
            send(0, 16'(i), 8, 8, 1'b1, 1'b0, 1'b0, i == 5);
        end
        clks(5); cs0 = 1'b1; clks(5);
        check("t4_we", 32'(we_cnt0 - base), 32'd5);
        check("t4_ovf", 32'(ovf0), 32'h0);
        check("t4_count", 32'(count0), 32'd4);
        for (int i = 0; i < 4; i++) pop_word(0);
        clks(1);

        // Frame error on a 3-bit partial word, then a clean frame.
        cs0 = 1'b0; clks(5);
        send(0, 16'h0005, 3, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        cs0 = 1'b1; clks(6);
        check("t5_ferr", 32'(ferr0), 32'h1);
        check("t5_count", 32'(count0), 32'd0);
        cs0 = 1'b0; clks(5);
        send8(8'h3C); exp_q0.push_back(16'h003C);
        clks(5); cs0 = 1'b1; clks(5);
        check("t5_rdata", 32'(rdata0), 32'h3C);
        pop_word(0);
        clr0 = 1'b1; clks(1); clr0 = 1'b0; clks(1);
        check("t5_ferr_cleared", 32'(ferr0), 32'h0);

        // Reset mid-word with two words buffered.
        cs0 = 1'b0; clks(5);
        send8(8'h11); send8(8'h22);
        send(0, 16'h0081, 3, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        nrst = 1'b0; #2;
        check_zero0("t6_reset");
        exp_q0.delete();
        clks(1); nrst = 1'b1; clks(1);
        base = we_cnt0;
        send(0, 16'h00FF, 5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        clks(5); cs0 = 1'b1; clks(6);
        check("t6_stale_count", 32'(count0), 32'd0);
        check("t6_stale_ferr", 32'(ferr0), 32'h0);
        cs0 = 1'b0; clks(5);
        send8(8'h81); exp_q0.push_back(16'h0081);
        clks(5); cs0 = 1'b1; clks(5);
        check("t6_we", 32'(we_cnt0 - base), 32'd1);
        check("t6_count", 32'(count0), 32'd1);
        check("t6_rdata", 32'(rdata0), 32'h81);
        pop_word(0); clks(1);
        check("t6_rvalid", 32'(rvalid0), 32'h0);

        clks(5);
        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
